// File: rtl/prism_cfg_loader_pkg.sv
// Shared types and constants for the PRISM config loader: FSM state codes and the staged entry layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package prism_cfg_loader_pkg;

  localparam int CFG_AW = 6;
  localparam int CFG_DW = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HALT    = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_CHECK   = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;

  typedef struct packed {
    logic [CFG_AW-1:0] addr;
    logic [CFG_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/prism_cfg_fifo.sv
// Synchronous staging FIFO with flush and exact occupancy level.
// Latency: push visible at head the cycle after; level updates the next cycle.
// Backpressure: push while full is dropped (even with a concurrent pop); flush overrides push and pop.
module prism_cfg_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 38
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/prism_cfg_loader.sv
// Stages (addr,data) writes and streams them into the PRISM debug port under reset; host passes through when idle.
// Latency: start -> RESET_CYCLES halt cycles, one write per cycle (two with PRISM_CFG_LOADER_VERIFY_EN), 1 release cycle.
// Backpressure: none upstream; full-FIFO pushes and busy-time host writes are dropped and flagged sticky.
module prism_cfg_loader
  import prism_cfg_loader_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int RESET_CYCLES = 2,
  parameter int AW           = CFG_AW,
  parameter int DW           = CFG_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_push,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [DW-1:0]          cfg_data,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear_err,
  input  logic                   host_wr,
  input  logic [AW-1:0]          host_addr,
  input  logic [DW-1:0]          host_wdata,
  input  logic                   host_reset,
  input  logic                   host_enable,
  input  logic [DW-1:0]          dbg_rdata,
  output logic                   dbg_wr,
  output logic [AW-1:0]          dbg_addr,
  output logic [DW-1:0]          dbg_wdata,
  output logic                   prism_reset,
  output logic                   prism_enable,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_overflow,
  output logic                   err_collide,
  output logic                   err_verify
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] HALT_LAST = CW'(RESET_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] halt_cnt;
  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic          push_ok, last_entry, verify_fail;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  // Abort beats push, so an aborted push never lands in the flushed FIFO.
  assign fifo_push  = cfg_push && !abort;
  assign push_ok    = fifo_push && !fifo_full;
  assign last_entry = (fifo_level == LW'(1)) && !push_ok;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_RELEASE) && !abort;

  prism_cfg_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({cfg_addr, cfg_data}),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  ({head_addr, head_data}),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    fifo_flush  = abort;
    verify_fail = 1'b0;
    case (state)
      ST_IDLE:    if (start && !fifo_empty) state_nxt = ST_HALT;
      ST_HALT:    if (halt_cnt == HALT_LAST) state_nxt = ST_LOAD;
`ifdef PRISM_CFG_LOADER_VERIFY_EN
      ST_LOAD:    state_nxt = fifo_empty ? ST_RELEASE : ST_CHECK;
      ST_CHECK: begin
        fifo_pop = 1'b1;
        if (dbg_rdata != head_data) begin
          verify_fail = 1'b1;
          fifo_flush  = 1'b1;
          state_nxt   = ST_RELEASE;
        end else begin
          state_nxt = last_entry ? ST_RELEASE : ST_LOAD;
        end
      end
`else
      ST_LOAD: begin
        fifo_pop = 1'b1;
        if (fifo_empty || last_entry) state_nxt = ST_RELEASE;
      end
`endif
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    dbg_wr       = 1'b0;
    dbg_addr     = head_addr;
    dbg_wdata    = head_data;
    prism_reset  = 1'b1;
    prism_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        dbg_wr       = host_wr;
        dbg_addr     = host_addr;
        dbg_wdata    = host_wdata;
        prism_reset  = host_reset;
        prism_enable = host_enable;
      end
      ST_LOAD:    dbg_wr = !fifo_empty;
      ST_RELEASE: prism_reset = 1'b0;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      halt_cnt     <= '0;
      err_overflow <= 1'b0;
      err_collide  <= 1'b0;
    end else begin
      state    <= state_nxt;
      halt_cnt <= ((state == ST_HALT) && (state_nxt == ST_HALT)) ? halt_cnt + CW'(1) : '0;
      if (fifo_push && fifo_full) err_overflow <= 1'b1;
      else if (clear_err)         err_overflow <= 1'b0;
      if (host_wr && busy)        err_collide  <= 1'b1;
      else if (clear_err)         err_collide  <= 1'b0;
    end
  end

`ifdef PRISM_CFG_LOADER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst)              err_verify <= 1'b0;
    else if (verify_fail) err_verify <= 1'b1;
    else if (clear_err)   err_verify <= 1'b0;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^{dbg_rdata, verify_fail};
  assign err_verify   = 1'b0;
`endif

endmodule
